fractal_frame_controller: RTL

//  Sequences fractal_generator frame by frame. It holds host-written shadow configuration and

---
 rtl/fractal_frame_controller_if.sv | 16 +
 rtl/fractal_frame_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fractal_frame_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : fractal_frame_controller_if
// Purpose : Host configuration bus into the frame controller's shadow registers.
// Revision: 1.0
// ============================================================================
interface fractal_frame_controller_if;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        cfg_commit;

   modport master (output cfg_we, cfg_addr, cfg_wdata, cfg_commit);
   modport slave  (input  cfg_we, cfg_addr, cfg_wdata, cfg_commit);
endinterface
`default_nettype wire

// File: rtl/fractal_frame_controller.sv
`default_nettype none
// ============================================================================
// Module  : fractal_frame_controller
// Purpose : Frame sequencer for fractal_generator: shadow/active config, restarts, cr/ci animation.
// Revision: 1.0
// ============================================================================
module fractal_frame_controller #(
   parameter int          RESET_CYCLES   = 4,
   parameter logic [15:0] DEFAULT_WIDTH  = 16'd384,
   parameter logic [15:0] DEFAULT_HEIGHT = 16'd216
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   fractal_frame_controller_if.slave     cfg,
   input  logic                          gen_frame_start,
   output logic                          gen_resetn,
   output logic [15:0]                   width,
   output logic [15:0]                   height,
   output logic [31:0]                   cr,
   output logic [31:0]                   ci,
   output logic [31:0]                   dx,
   output logic [31:0]                   dy,
   output logic [31:0]                   x0,
   output logic [31:0]                   y0,
   output logic                          commit_pending,
   output logic [31:0]                   frame_count,
   output logic [1:0]                    state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RESTART = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   // Animation step and period travel with the committed set so a commit is fully atomic.
   typedef struct packed {
      logic [15:0] width;
      logic [15:0] height;
      logic [31:0] cr;
      logic [31:0] ci;
      logic [31:0] dx;
      logic [31:0] dy;
      logic [31:0] x0;
      logic [31:0] y0;
      logic [31:0] dcr;
      logic [31:0] dci;
      logic [15:0] anim_frames;
   } params_t;

   localparam int      RC_W         = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam params_t RESET_PARAMS = '{DEFAULT_WIDTH, DEFAULT_HEIGHT, 32'd0, 32'd0, 32'd0,
                                        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0};

   state_t          state_q, state_d;
   params_t         shadow_q, shadow_d;
   params_t         active_q, active_d;
   logic            pending_q, pending_d;
   logic [15:0]     anim_cnt_q, anim_cnt_d;
   logic            dir_neg_q, dir_neg_d;
   logic [31:0]     frame_count_q, frame_count_d;
   logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
   logic            do_copy;
   logic [15:0]     anim_cnt_inc;

   always_comb begin
      shadow_d      = shadow_q;
      state_d       = state_q;
      active_d      = active_q;
      pending_d     = pending_q;
      anim_cnt_d    = anim_cnt_q;
      dir_neg_d     = dir_neg_q;
      frame_count_d = frame_count_q;
      rst_cnt_d     = rst_cnt_q;
      do_copy       = 1'b0;
      anim_cnt_inc  = anim_cnt_q + 16'd1;

      if (cfg.cfg_we) begin
         case (cfg.cfg_addr)
            4'd0:    shadow_d.width       = cfg.cfg_wdata[15:0];
            4'd1:    shadow_d.height      = cfg.cfg_wdata[15:0];
            4'd2:    shadow_d.cr          = cfg.cfg_wdata;
            4'd3:    shadow_d.ci          = cfg.cfg_wdata;
            4'd4:    shadow_d.dx          = cfg.cfg_wdata;
            4'd5:    shadow_d.dy          = cfg.cfg_wdata;
            4'd6:    shadow_d.x0          = cfg.cfg_wdata;
            4'd7:    shadow_d.y0          = cfg.cfg_wdata;
            4'd8:    shadow_d.dcr         = cfg.cfg_wdata;
            4'd9:    shadow_d.dci         = cfg.cfg_wdata;
            4'd10:   shadow_d.anim_frames = cfg.cfg_wdata[15:0];
            default: ;
         endcase
      end

      if (cfg.cfg_commit) begin
         pending_d = 1'b1;
      end

      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d       = ST_RESTART;
               do_copy       = 1'b1;
               frame_count_d = 32'd0;
               rst_cnt_d     = '0;
            end
            ST_RESTART: begin
               if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                  state_d = ST_RUN;
               end else begin
                  rst_cnt_d = rst_cnt_q + RC_W'(1);
               end
            end
            ST_RUN: begin
               if (gen_frame_start) begin
                  frame_count_d = frame_count_q + 32'd1;
                  if (pending_q || cfg.cfg_commit) begin
                     do_copy = 1'b1;
                     if ((shadow_q.width != active_q.width) ||
                         (shadow_q.height != active_q.height)) begin
                        state_d       = ST_RESTART;
                        frame_count_d = 32'd0;
                        rst_cnt_d     = '0;
                     end
                  end else if (active_q.anim_frames != 16'd0) begin
                     if (dir_neg_q) begin
                        active_d.cr = active_q.cr - active_q.dcr;
                        active_d.ci = active_q.ci - active_q.dci;
                     end else begin
                        active_d.cr = active_q.cr + active_q.dcr;
                        active_d.ci = active_q.ci + active_q.dci;
                     end
                     if (anim_cnt_inc == active_q.anim_frames) begin
                        anim_cnt_d = 16'd0;
                        dir_neg_d  = ~dir_neg_q;
                     end else begin
                        anim_cnt_d = anim_cnt_inc;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A copy always reads the pre-write shadow and restarts the ping-pong path.
      if (do_copy) begin
         active_d   = shadow_q;
         pending_d  = 1'b0;
         anim_cnt_d = 16'd0;
         dir_neg_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         shadow_q      <= RESET_PARAMS;
         active_q      <= RESET_PARAMS;
         pending_q     <= 1'b0;
         anim_cnt_q    <= 16'd0;
         dir_neg_q     <= 1'b0;
         frame_count_q <= 32'd0;
         rst_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         anim_cnt_q    <= anim_cnt_d;
         dir_neg_q     <= dir_neg_d;
         frame_count_q <= frame_count_d;
         rst_cnt_q     <= rst_cnt_d;
      end
   end

   assign gen_resetn     = (state_q == ST_RUN);
   assign width          = active_q.width;
   assign height         = active_q.height;
   assign cr             = active_q.cr;
   assign ci             = active_q.ci;
   assign dx             = active_q.dx;
   assign dy             = active_q.dy;
   assign x0             = active_q.x0;
   assign y0             = active_q.y0;
   assign commit_pending = pending_q;
   assign frame_count    = frame_count_q;
   assign state          = state_q;

endmodule
`default_nettype wire
